// File: rtl/action_rule_loader_if.sv
// Command and write-data channels between a rule source and action_rule_loader.
// cmd_clear is present only when ACTION_LOADER_CLEAR_EN is defined.
interface action_rule_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  // Handshake on both channels: a transfer happens on a rising edge where valid && ready.
  // The master holds valid and its payload stable until that edge; ready never depends on valid.
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_pdr;
  logic [8:0]            cmd_mask;
  logic                  wd_valid;
  logic                  wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;

`ifdef ACTION_LOADER_CLEAR_EN
  logic                  cmd_clear;

  modport master (
    output cmd_valid, cmd_pdr, cmd_mask, cmd_clear, wd_valid, wd_data,
    input  cmd_ready, wd_ready
  );

  modport slave (
    input  cmd_valid, cmd_pdr, cmd_mask, cmd_clear, wd_valid, wd_data,
    output cmd_ready, wd_ready
  );
`else
  modport master (
    output cmd_valid, cmd_pdr, cmd_mask, wd_valid, wd_data,
    input  cmd_ready, wd_ready
  );

  modport slave (
    input  cmd_valid, cmd_pdr, cmd_mask, wd_valid, wd_data,
    output cmd_ready, wd_ready
  );
`endif
endinterface

// File: rtl/action_rule_loader.sv
// Sequencer that installs one rule at a time into the per-field action memories.
// Optional zero-fill commands are enabled with ACTION_LOADER_CLEAR_EN.
module action_rule_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  action_rule_loader_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [8:0]            Write_Enables,
  output logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pdr,
  output logic                  lookup_stall,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           rule_count,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] pdr_q;
  logic [8:0]            rem_mask;
  logic [8:0]            rem_low;
  logic [8:0]            rem_after;
  logic                  cmd_fire;
  logic                  beat_fire;
  logic                  issue;
  logic                  clear_q;

  assign cmd_fire  = bus.cmd_valid & bus.cmd_ready;
  assign beat_fire = bus.wd_valid & bus.wd_ready;
  // Isolate the lowest pending field; fields are written in ascending order.
  assign rem_low   = rem_mask & (~rem_mask + 9'd1);
  assign rem_after = rem_mask & ~rem_low;

`ifdef ACTION_LOADER_CLEAR_EN
  logic [8:0] cmd_low;

  assign cmd_low = bus.cmd_mask & (~bus.cmd_mask + 9'd1);
  // A clear command writes its first field straight from acceptance, then one per cycle.
  assign issue   = beat_fire | (clear_q & (state == S_WRITE) & (rem_mask != 9'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      clear_q <= 1'b0;
    end else if (cmd_fire) begin
      clear_q <= bus.cmd_clear;
    end
  end
`else
  assign clear_q = 1'b0;
  assign issue   = beat_fire;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          state_nxt = (bus.cmd_mask == 9'd0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (clear_q) begin
          if (rem_mask == 9'd0) begin
            state_nxt = S_DONE;
          end
        end else if (beat_fire && (rem_after == 9'd0)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == S_IDLE);
    bus.wd_ready  = (state == S_WRITE) & ~clear_q;
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
  end

  // Covers the DONE cycle too, when the last field write is landing in memory.
  assign lookup_stall = lookup_valid & busy & (lookup_pdr == pdr_q);
  assign fsm_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      pdr_q         <= '0;
      rem_mask      <= '0;
      W_ADDR        <= '0;
      Write_Enables <= '0;
      Write_Data    <= '0;
      rule_count    <= '0;
    end else begin
      Write_Enables <= '0;
      if (cmd_fire) begin
        pdr_q    <= bus.cmd_pdr;
        rem_mask <= bus.cmd_mask;
`ifdef ACTION_LOADER_CLEAR_EN
        if (bus.cmd_clear && (bus.cmd_mask != 9'd0)) begin
          Write_Enables <= cmd_low;
          W_ADDR        <= bus.cmd_pdr;
          Write_Data    <= '0;
          rem_mask      <= bus.cmd_mask & ~cmd_low;
        end
`endif
      end else if (issue) begin
        Write_Enables <= rem_low;
        W_ADDR        <= pdr_q;
        Write_Data    <= clear_q ? '0 : bus.wd_data;
        rem_mask      <= rem_after;
      end
      if (state == S_DONE) begin
        rule_count <= rule_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_action_rule_loader.sv
// Randomized self-checking bench for action_rule_loader against a rule-level model.
// Define ACTION_LOADER_CLEAR_EN for both RTL and bench to exercise clear commands.
module tb_action_rule_loader;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int W  = 16 + 9 + AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] W_ADDR;
  logic [8:0]    Write_Enables;
  logic [DW-1:0] Write_Data;
  logic          lookup_valid = 1'b0;
  logic [AW-1:0] lookup_pdr = '0;
  logic          lookup_stall;
  logic          busy;
  logic          done;
  logic [15:0]   rule_count;
  logic [1:0]    fsm_state;

  action_rule_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  action_rule_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .W_ADDR       (W_ADDR),
    .Write_Enables(Write_Enables),
    .Write_Data   (Write_Data),
    .lookup_valid (lookup_valid),
    .lookup_pdr   (lookup_pdr),
    .lookup_stall (lookup_stall),
    .busy         (busy),
    .done         (done),
    .rule_count   (rule_count),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int m_rules  = 0;
  int lk_mode  = 0;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];
  int            exp_done_q[$];
  int            done_q[$];
  int            win_lo[$];
  int            win_hi[$];
  logic [AW-1:0] win_p[$];

  typedef struct {
    int            c;
    logic          v;
    logic [AW-1:0] p;
    logic          s;
  } lk_t;
  lk_t lk_log[$];

  always @(negedge clk) begin
    if (Write_Enables != 9'd0) obs_q.push_back({cyc[15:0], Write_Enables, W_ADDR, Write_Data});
    if (done === 1'b1) done_q.push_back(cyc);
    lk_log.push_back('{cyc, lookup_valid, lookup_pdr, lookup_stall});
  end

  // Background lookup traffic: random, or alternating pdr 3 / pdr 0 every cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (lk_mode == 1) begin
      lookup_valid = 1'b1;
      lookup_pdr   = (cyc % 2 == 0) ? AW'(3) : AW'(0);
    end else begin
      lookup_valid = 1'($urandom_range(0, 1));
      lookup_pdr   = AW'($urandom_range(0, 3));
    end
  end

  task automatic clear_logs();
    exp_q.delete();
    obs_q.delete();
    exp_done_q.delete();
    done_q.delete();
    lk_log.delete();
    win_lo.delete();
    win_hi.delete();
    win_p.delete();
  endtask

  // ---------------- driver + reference model ----------------
  // One field write per set mask bit, lowest first, landing the cycle after its beat.
  task automatic drive_rule(input logic [AW-1:0] pdr, input logic [8:0] mask,
                            input int gap_lo, input int gap_hi, input bit seq_data,
                            output int t_acc, output int t_done);
    int            bound;
    int            k;
    int            gap;
    int            wc;
    logic [15:0]   wc16;
    logic [8:0]    oh;
    logic [DW-1:0] d;
    bus.cmd_valid = 1'b1;
    bus.cmd_pdr   = pdr;
    bus.cmd_mask  = mask;
    bound = 0;
    while (!bus.cmd_ready && bound < 40) begin
      tick();
      bound++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept_timeout cmd_ready=%b want 1", bus.cmd_ready);
    end
    t_acc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_pdr   = AW'($urandom);
    bus.cmd_mask  = 9'($urandom);
    k      = 0;
    t_done = t_acc + 1;
    for (int i = 0; i < 9; i++) begin
      if (mask[i]) begin
        gap = (k == 0) ? 0 : int'($urandom_range(gap_lo, gap_hi));
        repeat (gap) begin
          bus.wd_valid = 1'b0;
          bus.wd_data  = $urandom;
          tick();
        end
        d = seq_data ? DW'(32'hA0 + k) : DW'($urandom);
        bus.wd_valid = 1'b1;
        bus.wd_data  = d;
        bound = 0;
        while (!bus.wd_ready && bound < 40) begin
          tick();
          bound++;
        end
        if (bus.wd_ready !== 1'b1) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_accept_timeout wd_ready=%b want 1", bus.wd_ready);
        end
        wc   = cyc + 1;
        wc16 = wc[15:0];
        oh   = 9'd1 << i;
        exp_q.push_back({wc16, oh, pdr, d});
        t_done = wc;
        tick();
        k++;
      end
    end
    bus.wd_valid = 1'b0;
    exp_done_q.push_back(t_done);
    win_lo.push_back(t_acc + 1);
    win_hi.push_back(t_done);
    win_p.push_back(pdr);
    m_rules++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_pdr   = '0;
    bus.cmd_mask  = '0;
    bus.wd_valid  = 1'b0;
    bus.wd_data   = '0;
`ifdef ACTION_LOADER_CLEAR_EN
    bus.cmd_clear = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    clear_logs();
    m_rules = 0;
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.wd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got ready=%b wd_ready=%b busy=%b done=%b want 1 0 0 0",
               bus.cmd_ready, bus.wd_ready, busy, done);
    end
    n_checks++;
    if (Write_Enables !== 9'd0 || W_ADDR !== '0 || Write_Data !== '0 || rule_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data got we=%h addr=%0d data=%h count=%0d want all zero",
               Write_Enables, W_ADDR, Write_Data, rule_count);
    end
    // Stray write-data in IDLE must be ignored.
    repeat (5) begin
      bus.wd_valid = 1'($urandom_range(0, 1));
      bus.wd_data  = $urandom;
      tick();
    end
    bus.wd_valid = 1'b0;
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || rule_count !== 16'd0 || bus.wd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold got ready=%b count=%0d wd_ready=%b want 1 0 0",
               bus.cmd_ready, rule_count, bus.wd_ready);
    end
    n_checks++;
    if (obs_q.size() != 0 || done_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_activity got writes=%0d dones=%0d want 0 0", obs_q.size(), done_q.size());
    end
    foreach (lk_log[j]) begin
      n_checks++;
      if (lk_log[j].s !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_stall cyc=%0d got %b want 0", lk_log[j].c, lk_log[j].s);
      end
    end
  endtask

  task automatic test_reset_mid_rule();
    logic [DW-1:0] d;
    int            t;
    int            wc;
    logic [15:0]   wc16;
    clear_logs();
    bus.cmd_valid = 1'b1;
    bus.cmd_pdr   = AW'(1);
    bus.cmd_mask  = 9'h01F;
    tick();
    bus.cmd_valid = 1'b0;
    t = cyc;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      bus.wd_valid = 1'b1;
      bus.wd_data  = d;
      wc   = cyc + 1;
      wc16 = wc[15:0];
      exp_q.push_back({wc16, 9'(9'd1 << i), AW'(1), d});
      tick();
    end
    // Third beat is offered in the same cycle the reset is asserted.
    bus.wd_data = $urandom;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wd_valid = 1'b0;
    m_rules = 0;
    n_checks++;
    if (Write_Enables !== 9'd0 || W_ADDR !== '0 || Write_Data !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || bus.cmd_ready !== 1'b1 || rule_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_values got we=%h addr=%0d data=%h busy=%b done=%b ready=%b count=%0d want reset values",
               Write_Enables, W_ADDR, Write_Data, busy, done, bus.cmd_ready, rule_count);
    end
    repeat (4) tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midrst_write_count got %0d want %0d (cmd at %0d)", obs_q.size(), exp_q.size(), t);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_q.size() != 0 || rule_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_done got dones=%0d count=%0d want 0 0", done_q.size(), rule_count);
    end
  endtask

  task automatic test_full_mask();
    int ta;
    int td;
    clear_logs();
    drive_rule(AW'(2), 9'h1FF, 0, 0, 1'b1, ta, td);
    n_checks++;
    if (cyc != ta + 10 || done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done_cycle got cyc=%0d done=%b ready=%b want cyc=%0d done=1 ready=0",
               cyc, done, bus.cmd_ready, ta + 10);
    end
    tick();
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready_after got ready=%b busy=%b want 1 0", bus.cmd_ready, busy);
    end
    tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL full_write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != exp_done_q[0]) begin
      n_fail++;
      $display("FAIL full_done got n=%0d first=%0d want n=1 at %0d", done_q.size(), done_q[0], exp_done_q[0]);
    end
    n_checks++;
    if (rule_count !== 16'(m_rules)) begin
      n_fail++;
      $display("FAIL full_count got %0d want %0d", rule_count, m_rules);
    end
  endtask

  task automatic test_gapped();
    int ta;
    int td;
    clear_logs();
    drive_rule(AW'(1), 9'h011, 3, 3, 1'b0, ta, td);
    repeat (2) tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL gap_write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gap_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != exp_done_q[0]) begin
      n_fail++;
      $display("FAIL gap_done got n=%0d first=%0d want n=1 at %0d", done_q.size(), done_q[0], exp_done_q[0]);
    end
    n_checks++;
    if (rule_count !== 16'(m_rules)) begin
      n_fail++;
      $display("FAIL gap_count got %0d want %0d", rule_count, m_rules);
    end
  endtask

  task automatic test_zero_mask();
    int ta;
    int td;
    int ta2;
    int td2;
    clear_logs();
    drive_rule(AW'(0), 9'h000, 0, 0, 1'b0, ta, td);
    n_checks++;
    if (cyc != ta + 1 || done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got cyc=%0d done=%b ready=%b want cyc=%0d done=1 ready=0",
               cyc, done, bus.cmd_ready, ta + 1);
    end
    drive_rule(AW'(1), 9'h000, 0, 0, 1'b0, ta2, td2);
    n_checks++;
    if (ta2 != ta + 2) begin
      n_fail++;
      $display("FAIL zero_next_accept got %0d want %0d", ta2, ta + 2);
    end
    repeat (2) tick();
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_writes got %0d want 0", obs_q.size());
    end
    n_checks++;
    if (done_q.size() != 2 || done_q[0] != exp_done_q[0] || done_q[1] != exp_done_q[1]) begin
      n_fail++;
      $display("FAIL zero_dones got n=%0d first=%0d want n=2 first=%0d", done_q.size(), done_q[0], exp_done_q[0]);
    end
    n_checks++;
    if (rule_count !== 16'(m_rules)) begin
      n_fail++;
      $display("FAIL zero_count got %0d want %0d", rule_count, m_rules);
    end
  endtask

  task automatic test_stall();
    int   ta;
    int   td;
    logic e;
    int   hits;
    clear_logs();
    lk_mode = 1;
    drive_rule(AW'(3), 9'($urandom_range(1, 511)), 0, 2, 1'b0, ta, td);
    repeat (2) tick();
    lk_mode = 0;
    hits = 0;
    foreach (lk_log[j]) begin
      e = 1'b0;
      foreach (win_lo[w]) begin
        if (lk_log[j].v && lk_log[j].c >= win_lo[w] && lk_log[j].c <= win_hi[w] && lk_log[j].p == win_p[w]) e = 1'b1;
      end
      if (e) hits++;
      n_checks++;
      if (lk_log[j].s !== e) begin
        n_fail++;
        $display("FAIL stall cyc=%0d pdr=%0d got %b want %b", lk_log[j].c, lk_log[j].p, lk_log[j].s, e);
      end
    end
    n_checks++;
    if (hits == 0) begin
      n_fail++;
      $display("FAIL stall_window got 0 stalled lookups want >0 (cmd %0d..%0d)", ta, td);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size() || done_q.size() != 1) begin
      n_fail++;
      $display("FAIL stall_rule got writes=%0d dones=%0d want %0d 1", obs_q.size(), done_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int         ta;
    int         td;
    int         prev_td;
    logic [8:0] mask;
    logic       e;
    clear_logs();
    prev_td = -1;
    for (int r = 0; r < 8; r++) begin
      mask = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom_range(1, 511));
      drive_rule(AW'($urandom_range(0, 3)), mask, 0, 2, 1'b0, ta, td);
      if (prev_td >= 0) begin
        n_checks++;
        if (ta != prev_td + 1) begin
          n_fail++;
          $display("FAIL b2b_accept[%0d] got %0d want %0d", r, ta, prev_td + 1);
        end
      end
      prev_td = td;
    end
    repeat (2) tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_q.size() != exp_done_q.size()) begin
      n_fail++;
      $display("FAIL b2b_done_count got %0d want %0d", done_q.size(), exp_done_q.size());
    end
    for (int i = 0; i < exp_done_q.size() && i < done_q.size(); i++) begin
      n_checks++;
      if (done_q[i] != exp_done_q[i]) begin
        n_fail++;
        $display("FAIL b2b_done[%0d] got %0d want %0d", i, done_q[i], exp_done_q[i]);
      end
    end
    foreach (lk_log[j]) begin
      e = 1'b0;
      foreach (win_lo[w]) begin
        if (lk_log[j].v && lk_log[j].c >= win_lo[w] && lk_log[j].c <= win_hi[w] && lk_log[j].p == win_p[w]) e = 1'b1;
      end
      n_checks++;
      if (lk_log[j].s !== e) begin
        n_fail++;
        $display("FAIL b2b_stall cyc=%0d pdr=%0d got %b want %b", lk_log[j].c, lk_log[j].p, lk_log[j].s, e);
      end
    end
    n_checks++;
    if (rule_count !== 16'(m_rules)) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want %0d", rule_count, m_rules);
    end
  endtask

`ifdef ACTION_LOADER_CLEAR_EN
  task automatic test_clear();
    int          ta;
    int          wc;
    logic [15:0] wc16;
    clear_logs();
    bus.cmd_valid = 1'b1;
    bus.cmd_pdr   = AW'(0);
    bus.cmd_mask  = 9'h003;
    bus.cmd_clear = 1'b1;
    bus.wd_valid  = 1'b1;
    bus.wd_data   = $urandom;
    ta = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wc   = ta + 1 + i;
      wc16 = wc[15:0];
      exp_q.push_back({wc16, 9'(9'd1 << i), AW'(0), DW'(0)});
    end
    m_rules++;
    repeat (4) begin
      n_checks++;
      if (bus.wd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_wd_ready cyc=%0d got %b want 0", cyc, bus.wd_ready);
      end
      bus.wd_data = $urandom;
      tick();
    end
    bus.wd_valid = 1'b0;
    tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL clear_write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL clear_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != ta + 3 || rule_count !== 16'(m_rules)) begin
      n_fail++;
      $display("FAIL clear_done got n=%0d at %0d count=%0d want n=1 at %0d count=%0d",
               done_q.size(), done_q[0], rule_count, ta + 3, m_rules);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_reset_mid_rule();
    test_full_mask();
    test_gapped();
    test_zero_mask();
    test_stall();
    test_back_to_back();
`ifdef ACTION_LOADER_CLEAR_EN
    test_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog cyc=%0d got no completion want finish", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
